shared_mem_arb: RTL and testbench

- Synthesizable single-array program/data memory shared by the processor's fetch port and load/store port.
- Replaces the behavioural bench memory, which had unlimited ports and zero latency.
- Parametrised in word width, depth and read latency.
- Arbitrates one access per cycle between the two ports with a starvation-free priority rule; returns read data through a fixed-latency pipeline.

---
 rtl/shared_mem_arb.sv | 109 ++++++++++
 tb/tb_shared_mem_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arb.sv
// rtl/shared_mem_arb.sv - single-array memory shared by fetch and load/store ports, fixed-latency reads
// Optional byte-enable writes on the data port when SHARED_MEM_BYTE_EN_EN is defined.
module shared_mem_arb #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
`ifdef SHARED_MEM_BYTE_EN_EN
  input  logic [WIDTH/8-1:0] d_be,
`endif
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              if_starved_q, if_starved_d;
  logic              acc_rd, acc_wr, acc_tag, acc_in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic [IDX_W-1:0]  acc_idx;

  logic [LAT-1:0]    pv_q;
  logic [LAT-1:0]    ptag_q;
  logic [WIDTH-1:0]  pdata_q [LAT];
  logic [WIDTH-1:0]  if_hold_q, d_hold_q;

  // Data port wins ties unless fetch was turned away last cycle.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      d_gnt  = d_req  & (~if_req | ~if_starved_q);
      if_gnt = if_req & (~d_req  |  if_starved_q);
    end
    if_starved_d = if_req & ~if_gnt;
    acc_addr     = d_gnt ? d_addr : if_addr;
    acc_in_range = ({1'b0, acc_addr} < DEPTH_A);
    acc_idx      = acc_addr[IDX_W-1:0];
    acc_wr       = d_gnt & d_we & acc_in_range;
    acc_rd       = if_gnt | (d_gnt & ~d_we);
    acc_tag      = if_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_starved_q <= 1'b0;
    end else begin
      if_starved_q <= if_starved_d;
    end
  end

  // Array contents deliberately survive reset.
`ifdef SHARED_MEM_BYTE_EN_EN
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (d_be[b]) mem_q[acc_idx][b*8 +: 8] <= d_wdata[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (acc_wr) mem_q[acc_idx] <= d_wdata;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q      <= '0;
      ptag_q    <= '0;
      for (int k = 0; k < LAT; k++) pdata_q[k] <= '0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      pv_q[0]    <= acc_rd;
      ptag_q[0]  <= acc_tag;
      pdata_q[0] <= acc_in_range ? mem_q[acc_idx] : '0;
      for (int k = 1; k < LAT; k++) begin
        pv_q[k]    <= pv_q[k-1];
        ptag_q[k]  <= ptag_q[k-1];
        pdata_q[k] <= pdata_q[k-1];
      end
      if (if_rvalid) if_hold_q <= pdata_q[LAT-1];
      if (d_rvalid)  d_hold_q  <= pdata_q[LAT-1];
    end
  end

  // rdata shows the last delivered word whenever its rvalid is low.
  assign if_rvalid = pv_q[LAT-1] &  ptag_q[LAT-1];
  assign d_rvalid  = pv_q[LAT-1] & ~ptag_q[LAT-1];
  assign if_rdata  = if_rvalid ? pdata_q[LAT-1] : if_hold_q;
  assign d_rdata   = d_rvalid  ? pdata_q[LAT-1] : d_hold_q;

endmodule

// File: tb/tb_shared_mem_arb.sv
// tb/tb_shared_mem_arb.sv - scoreboard bench driving LAT=1 and LAT=3 instances with identical stimulus
module tb_shared_mem_arb;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;

  typedef struct {
    int              port;
    logic [WIDTH-1:0] data;
    int              due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [WIDTH-1:0]  d_wdata;
`ifdef SHARED_MEM_BYTE_EN_EN
  logic [WIDTH/8-1:0] d_be;
`endif
  logic [1:0] if_gnt_w, if_rvalid_w, d_gnt_w, d_rvalid_w;
  logic [WIDTH-1:0] if_rdata_w [2];
  logic [WIDTH-1:0] d_rdata_w  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_mem_arb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[0]),
    .if_rvalid(if_rvalid_w[0]), .if_rdata(if_rdata_w[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef SHARED_MEM_BYTE_EN_EN
    .d_be(d_be),
`endif
    .d_gnt(d_gnt_w[0]), .d_rvalid(d_rvalid_w[0]), .d_rdata(d_rdata_w[0])
  );

  shared_mem_arb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[1]),
    .if_rvalid(if_rvalid_w[1]), .if_rdata(if_rdata_w[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef SHARED_MEM_BYTE_EN_EN
    .d_be(d_be),
`endif
    .d_gnt(d_gnt_w[1]), .d_rvalid(d_rvalid_w[1]), .d_rdata(d_rdata_w[1])
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  function automatic void cmp_resp(input int k, input exp_t e, input logic iv,
                                   input logic [WIDTH-1:0] id, input logic [WIDTH-1:0] dd);
    chk($sformatf("dut%0d resp port", k), iv ? 0 : 1, e.port);
    chk($sformatf("dut%0d resp data", k), iv ? id : dd, e.data);
    chk($sformatf("dut%0d resp cycle", k), cyc, e.due);
  endfunction

  // port: 0 = fetch, 1 = data. Fetch response due one cycle later on dut0, three on dut1.
  task automatic push(input int port, input logic [WIDTH-1:0] data, input bit to_lat3);
    q0.push_back('{port: port, data: data, due: cyc + 1});
    if (to_lat3) q1.push_back('{port: port, data: data, due: cyc + 3});
  endtask

  // Called just after a rising edge; a lone request must be granted in its first cycle.
  task automatic do_op(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [WIDTH-1:0] data, input bit to_lat3);
    if (port == 0) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = we ? data : '0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d lone gnt", k), (port == 0) ? if_gnt_w[k] : d_gnt_w[k], 1);
      chk($sformatf("dut%0d lone other gnt", k), (port == 0) ? d_gnt_w[k] : if_gnt_w[k], 0);
    end
    if (!we) push(port, data, to_lat3);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].due < cyc) begin
      flag("dut0 missing response");
      void'(q0.pop_front());
    end
    if (if_rvalid_w[0] || d_rvalid_w[0]) begin
      if (q0.size() == 0) flag("dut0 unexpected rvalid");
      else begin
        e = q0.pop_front();
        cmp_resp(0, e, if_rvalid_w[0], if_rdata_w[0], d_rdata_w[0]);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0 && q1[0].due < cyc) begin
      flag("dut1 missing response");
      void'(q1.pop_front());
    end
    if (if_rvalid_w[1] || d_rvalid_w[1]) begin
      if (q1.size() == 0) flag("dut1 unexpected rvalid");
      else begin
        e = q1.pop_front();
        cmp_resp(1, e, if_rvalid_w[1], if_rdata_w[1], d_rdata_w[1]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_d;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
`ifdef SHARED_MEM_BYTE_EN_EN
    d_be = '1;
`endif
    // Reset held two cycles with both ports requesting.
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d rst if_gnt", k), if_gnt_w[k], 0);
        chk($sformatf("dut%0d rst d_gnt", k), d_gnt_w[k], 0);
        chk($sformatf("dut%0d rst rvalids", k), {if_rvalid_w[k], d_rvalid_w[k]}, 0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d post-rst rvalids", k), {if_rvalid_w[k], d_rvalid_w[k]}, 0);
      chk($sformatf("dut%0d post-rst if_rdata", k), if_rdata_w[k], 0);
      chk($sformatf("dut%0d post-rst d_rdata", k), d_rdata_w[k], 0);
    end
    @(posedge clk); #1;

    do_op(1, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    do_op(0, 1'b0, 16'h0010, 16'hBEEF, 1'b1);
    do_op(1, 1'b1, 16'h0001, 16'h1111, 1'b1);
    do_op(1, 1'b1, 16'h0002, 16'h2222, 1'b1);
    do_op(1, 1'b1, 16'h0000, 16'hCAFE, 1'b1);

    // Continuous contention: grants alternate d, i, d, i ...
    if_req = 1'b1; if_addr = 16'h0002;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_d = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d contend d_gnt %0d", k, i), d_gnt_w[k], exp_d);
        chk($sformatf("dut%0d contend if_gnt %0d", k, i), if_gnt_w[k], !exp_d);
      end
      push(exp_d ? 1 : 0, exp_d ? 16'h1111 : 16'h2222, 1'b1);
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    do_op(1, 1'b0, 16'h0010, 16'hBEEF, 1'b1);
    do_op(1, 1'b0, 16'h0002, 16'h2222, 1'b1);
    do_op(1, 1'b1, 16'h0020, 16'h7777, 1'b1);
    do_op(1, 1'b0, 16'h0020, 16'h7777, 1'b1);
    do_op(1, 1'b1, 16'h0021, 16'h0BAD, 1'b1);
    do_op(0, 1'b0, 16'h0021, 16'h0BAD, 1'b1);

    // Out-of-range: write dropped (must not alias onto 0x0000), reads give zero.
    do_op(1, 1'b1, 16'h0400, 16'h1234, 1'b1);
    do_op(1, 1'b0, 16'h0400, 16'h0000, 1'b1);
    do_op(0, 1'b0, 16'h0000, 16'hCAFE, 1'b1);
    do_op(0, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // Reset one cycle after a grant: LAT=1 already delivered, LAT=3 must drop it.
    do_op(1, 1'b0, 16'h0001, 16'h1111, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d mid-rst d_rdata", k), d_rdata_w[k], 0);
      chk($sformatf("dut%0d mid-rst rvalids", k), {if_rvalid_w[k], d_rvalid_w[k]}, 0);
    end
    @(posedge clk); #1;
    do_op(0, 1'b0, 16'h0010, 16'hBEEF, 1'b1);
    do_op(1, 1'b0, 16'h0020, 16'h7777, 1'b1);

`ifdef SHARED_MEM_BYTE_EN_EN
    d_be = 2'b11;
    do_op(1, 1'b1, 16'h0030, 16'hAAAA, 1'b1);
    d_be = 2'b01;
    do_op(1, 1'b1, 16'h0030, 16'h5555, 1'b1);
    d_be = 2'b00;
    do_op(1, 1'b1, 16'h0030, 16'h0000, 1'b1);
    d_be = 2'b10;
    do_op(1, 1'b0, 16'h0030, 16'hAA55, 1'b1);
    d_be = 2'b11;
`endif

    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
